alu64: RTL and testbench
========================

# alu64

Registered 64-bit integer ALU for the LEGv8 single-cycle/pipelined datapath. Each clock it computes AND, OR, ADD, SUB or pass-B on two 64-bit operands, selected by a 4-bit ALU control code. It registers the result together with a zero flag, which feeds the CBZ/branch logic and the write-back path.

## Interface
Parameters:
- `N`, default 64: operand and result width.

Ports:
- `clk`, in, 1: system clock. All state updates on the rising edge.
- `reset`, in, 1: reset is synchronous and active-high.
- `a`, in, N: operand A.
- `b`, in, N: operand B.
- `ALUControl`, in, 4: operation select.
- `result`, out, N: registered operation result.
- `zero`, out, 1: registered flag, 1 when the computed result is all zeros.
- `negative`, `carry`, `overflow`, out, 1 each: present only when `ALU_FLAGS_EN` is defined.

## Operation
ALUControl decode:
- 4'b0000 AND: `a & b`.
- 4'b0001 OR: `a | b`.
- 4'b0010 ADD: `a + b` modulo 2^N. The carry-out is discarded from `result`.
- 4'b0110 SUB: `a + ~b + 1` modulo 2^N.
- 4'b0111 PASS_B: `b`.
- Any other code: result 0, so zero = 1. No X propagation.

Zero flag:
- `zero` is computed from the next-result value, i.e. the reduction NOR of the 64-bit result.
- It is registered in the same cycle as `result`.

Arithmetic:
- Operands are treated as unsigned bit vectors for `result`.
- Wrap-around is silent: ADD of 64'hFFFF_FFFF_FFFF_FFFF and 1 gives 0 with zero = 1.

Flags with `ALU_FLAGS_EN`:
- `negative` = result[N-1].
- `carry` = adder carry-out. For SUB, carry = 1 means no borrow.
- `overflow` = signed two's-complement overflow.
- All three are 0 for logic and pass/unused codes.

## Timing
- Latency is 1 cycle: inputs sampled at rising edge k appear on `result`/`zero` after edge k.
- There is no handshake. A new operation can be issued every cycle; throughput is 1 per cycle.
- Reset values: result = 0, zero = 1, and negative/carry/overflow = 0.
- `reset` asserted at an edge overrides any in-flight operation. The operation presented at that edge is discarded, not delayed.
- Outputs hold their value between edges. Input changes between edges have no effect on outputs.

## Configuration
- `ALU_FLAGS_EN` defined: the ports `negative`, `carry`, `overflow` exist and are registered as above.
- `ALU_FLAGS_EN` undefined: those ports and their registers are absent. `result`/`zero` behaviour is identical in both builds.

## Structure
- Shared package `alu_pkg` holds:
  - `alu_op_t` (4-bit enum: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_PASSB=0111);
  - the width constant `ALU_W = 64`.
- One sub-module, `alu_addsub`: an N-bit adder with a `sub` input that inverts b and sets carry-in. It outputs sum, carry-out and signed overflow.
- The top level does the combinational decode, then the output register stage.

## Test plan
- a=2, b=1, one cycle per code: AND→0 (zero=1); OR→3; ADD→3; SUB→1; PASS_B→1. zero=0 for all except AND.
- a=64'hFFFF_FFFF_FFFF_FFFF, b=1:
  - AND→1;
  - OR→all ones;
  - ADD→0 with zero=1 (carry=1 if flags enabled);
  - SUB→64'hFFFF_FFFF_FFFF_FFFE;
  - PASS_B→1.
- Undefined code 4'b0011 with a=5, b=7 → result 0, zero=1.
- Reset asserted while ADD a=3, b=4 is presented → next edge gives result 0, zero=1. First edge after release gives 7.
- Latency: change inputs mid-cycle → outputs unchanged until the next rising edge. Back-to-back ops update every cycle.
- Flags (`ALU_FLAGS_EN`): a=64'h7FFF_FFFF_FFFF_FFFF, b=1, ADD → overflow=1, negative=1, carry=0.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the alu64 slice.
//   ALU_W    : default operand/result width (64).
//   alu_op_t : 4-bit ALU control encoding (AND, OR, ADD, SUB, PASS_B).
//   op_is_arith() : true for the codes that go through the adder.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 64;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111
    } alu_op_t;

    // Status flags (negative/carry/overflow) are only meaningful for adder ops.
    function automatic logic op_is_arith(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu64_if.sv
// ---------------------------------------------------------------------------
// alu64_if -- operand/result bundle for the registered ALU.
//   master : drives a, b, ALUControl; observes result, zero (+ flags).
//   slave  : the ALU itself; observes operands, drives result, zero (+ flags).
// Optional feature macro: ALU_FLAGS_EN adds negative, carry, overflow.
// ---------------------------------------------------------------------------
interface alu64_if
    import alu_pkg::*;
#(
    parameter int N = ALU_W
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ALUControl;
    logic [N-1:0] result;
    logic         zero;
`ifdef ALU_FLAGS_EN
    logic         negative;
    logic         carry;
    logic         overflow;
`endif

    modport master (
        output a, b, ALUControl,
        input  result, zero
`ifdef ALU_FLAGS_EN
        , input negative, carry, overflow
`endif
    );

    modport slave (
        input  a, b, ALUControl,
        output result, zero
`ifdef ALU_FLAGS_EN
        , output negative, carry, overflow
`endif
    );

endinterface

// File: rtl/alu_addsub.sv
// ---------------------------------------------------------------------------
// alu_addsub -- N-bit combinational adder/subtractor.
//   a, b     : operands
//   sub      : 1 = a - b (b inverted, carry-in 1), 0 = a + b
//   sum      : N-bit result modulo 2^N
//   carry    : adder carry-out (for subtraction, 1 means no borrow)
//   overflow : signed two's-complement overflow
// ---------------------------------------------------------------------------
module alu_addsub
    import alu_pkg::*;
#(
    parameter int N = ALU_W
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         overflow
);

    logic [N-1:0] b_op_s;
    logic [N:0]   wide_s;

    // Conditionally invert b and run one extended-width add with carry-in = sub.
    always_comb begin
        b_op_s   = sub ? ~b : b;
        wide_s   = {1'b0, a} + {1'b0, b_op_s} + {{N{1'b0}}, sub};
        sum      = wide_s[N-1:0];
        carry    = wide_s[N];
        // Same-sign inputs to the adder producing a different-sign sum.
        overflow = (a[N-1] == b_op_s[N-1]) && (wide_s[N-1] != a[N-1]);
    end

endmodule

// File: rtl/alu64.sv
// ---------------------------------------------------------------------------
// alu64 -- registered integer ALU for the LEGv8 datapath.
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high; clears result, sets zero
//   bus   : alu64_if.slave -- a, b, ALUControl in; result, zero out
// One cycle of latency, one operation per cycle, no handshake.
// Unknown control codes yield result 0 / zero 1.
// Optional feature macro: ALU_FLAGS_EN registers negative, carry, overflow
// (forced to 0 for logic, pass and unused codes).
// ---------------------------------------------------------------------------
module alu64
    import alu_pkg::*;
#(
    parameter int N = ALU_W
) (
    input  logic    clk,
    input  logic    reset,
    alu64_if.slave  bus
);

    alu_op_t      op_s;
    logic         sub_s;
    logic [N-1:0] sum_s;
    logic         carry_s;
    logic         overflow_s;
    logic [N-1:0] next_result_s;
    logic         next_zero_s;

    logic [N-1:0] result_r;
    logic         zero_r;

    assign op_s  = alu_op_t'(bus.ALUControl);
    assign sub_s = (bus.ALUControl == ALU_SUB);

    alu_addsub #(.N(N)) u_addsub (
        .a        (bus.a),
        .b        (bus.b),
        .sub      (sub_s),
        .sum      (sum_s),
        .carry    (carry_s),
        .overflow (overflow_s)
    );

    // Operation decode into the next result; unknown codes collapse to 0.
    always_comb begin
        next_result_s = {N{1'b0}};
        case (op_s)
            ALU_AND:   next_result_s = bus.a & bus.b;
            ALU_OR:    next_result_s = bus.a | bus.b;
            ALU_ADD:   next_result_s = sum_s;
            ALU_SUB:   next_result_s = sum_s;
            ALU_PASSB: next_result_s = bus.b;
            default:   next_result_s = {N{1'b0}};
        endcase
        next_zero_s = ~|next_result_s;
    end

    // Output register for result and zero; reset discards the presented op.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= {N{1'b0}};
            zero_r   <= 1'b1;
        end else begin
            result_r <= next_result_s;
            zero_r   <= next_zero_s;
        end
    end

    assign bus.result = result_r;
    assign bus.zero   = zero_r;

`ifdef ALU_FLAGS_EN
    logic arith_s;
    logic negative_r;
    logic carry_r;
    logic overflow_r;

    assign arith_s = op_is_arith(bus.ALUControl);

    // Status flag register; flags only report on adder operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            negative_r <= 1'b0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            negative_r <= arith_s & next_result_s[N-1];
            carry_r    <= arith_s & carry_s;
            overflow_r <= arith_s & overflow_s;
        end
    end

    assign bus.negative = negative_r;
    assign bus.carry    = carry_r;
    assign bus.overflow = overflow_r;
`else
    // Adder status outputs have no consumer when the flag ports are absent.
    logic unused_flags_s;
    assign unused_flags_s = carry_s ^ overflow_s;
`endif

endmodule

// File: tb/tb_alu64.sv
// ---------------------------------------------------------------------------
// tb_alu64 -- self-checking bench for alu64: directed cases for each code,
// wrap-around, unknown codes, reset override and latency, then a randomized
// run against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu64;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu64_if #(.N(64)) bus ();

    alu64 #(.N(64)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, flags from 65-bit extended math.
    task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic z,
                         output logic n, output logic c, output logic v);
        logic [64:0]        wide;
        logic signed [64:0] sw;
        n = 1'b0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[63:0];
                c    = wide[64];
                sw   = $signed({a[63], a}) + $signed({b[63], b});
                v    = (sw[64] != sw[63]);
                n    = r[63];
            end
            4'd6: begin
                r  = a - b;
                c  = (a >= b);
                sw = $signed({a[63], a}) - $signed({b[63], b});
                v  = (sw[64] != sw[63]);
                n  = r[63];
            end
            4'd7: r = b;
            default: r = 64'd0;
        endcase
        z = (r == 64'd0);
    endtask

    task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bus.ALUControl = op;
        bus.a          = a;
        bus.b          = b;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic z, n, c, v;
        model(op, a, b, r, z, n, c, v);
        check_eq({tag, ".result"}, bus.result, r);
        check_eq({tag, ".zero"}, {63'd0, bus.zero}, {63'd0, z});
`ifdef ALU_FLAGS_EN
        check_eq({tag, ".nzcv"}, {61'd0, bus.negative, bus.carry, bus.overflow},
                 {61'd0, n, c, v});
`endif
    endtask

    // Issue one operation, wait one edge, compare against the model.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [63:0] a, input logic [63:0] b);
        drive(op, a, b);
        @(posedge clk);
        #1;
        check_outputs(tag, op, a, b);
    endtask

    logic [63:0] ones;
    logic [3:0]  codes [5];
    logic [63:0] edge_vals [6];

    initial begin
        checks   = 0;
        failures = 0;
        ones     = 64'hFFFF_FFFF_FFFF_FFFF;
        codes    = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
        edge_vals = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                      64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd2};

        // Reset state
        reset = 1'b1;
        drive(4'b0001, 64'hDEAD, 64'hBEEF);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.result", bus.result, 64'd0);
        check_eq("rst.zero", {63'd0, bus.zero}, 64'd1);
`ifdef ALU_FLAGS_EN
        check_eq("rst.nzcv", {61'd0, bus.negative, bus.carry, bus.overflow}, 64'd0);
`endif
        reset = 1'b0;

        // a=2, b=1 through each defined code, back-to-back
        run_op("small.and", 4'b0000, 64'd2, 64'd1);
        check_eq("small.and.lit", bus.result, 64'd0);
        run_op("small.or", 4'b0001, 64'd2, 64'd1);
        check_eq("small.or.lit", bus.result, 64'd3);
        run_op("small.add", 4'b0010, 64'd2, 64'd1);
        check_eq("small.add.lit", bus.result, 64'd3);
        run_op("small.sub", 4'b0110, 64'd2, 64'd1);
        check_eq("small.sub.lit", bus.result, 64'd1);
        run_op("small.passb", 4'b0111, 64'd2, 64'd1);

        // all-ones against 1: wrap-around boundary
        run_op("ones.and", 4'b0000, ones, 64'd1);
        run_op("ones.or", 4'b0001, ones, 64'd1);
        run_op("ones.add", 4'b0010, ones, 64'd1);
        check_eq("ones.add.lit", {bus.result[62:0], bus.zero}, 64'd1);
        run_op("ones.sub", 4'b0110, ones, 64'd1);
        check_eq("ones.sub.lit", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("ones.passb", 4'b0111, ones, 64'd1);

        // Unknown code
        run_op("undef.0011", 4'b0011, 64'd5, 64'd7);
        check_eq("undef.lit", {bus.result[62:0], bus.zero}, 64'd1);

        // Signed overflow boundary
        run_op("ovf.add", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        run_op("ovf.sub", 4'b0110, 64'h8000_0000_0000_0000, 64'd1);

        // Reset overrides the operation presented at the same edge
        run_op("pre_rst", 4'b0001, 64'hF0, 64'h0F);
        reset = 1'b1;
        drive(4'b0010, 64'd3, 64'd4);
        @(posedge clk);
        #1;
        check_eq("rst_ovr.result", bus.result, 64'd0);
        check_eq("rst_ovr.zero", {63'd0, bus.zero}, 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_rel.result", bus.result, 64'd7);
        check_eq("rst_rel.zero", {63'd0, bus.zero}, 64'd0);

        // Mid-cycle input change must not reach the outputs before the edge
        run_op("lat.base", 4'b0010, 64'd10, 64'd20);
        drive(4'b0001, 64'h100, 64'h001);
        #3;
        check_eq("lat.hold.result", bus.result, 64'd30);
        check_eq("lat.hold.zero", {63'd0, bus.zero}, 64'd0);
        @(posedge clk);
        #1;
        check_outputs("lat.next", 4'b0001, 64'h100, 64'h001);

        // Randomized run: mostly defined codes, some unknown, biased operands
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  op;
            logic [63:0] ra, rb;
            if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(0, 15));
            else                            op = codes[$urandom_range(0, 4)];
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = edge_vals[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) rb = edge_vals[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op("rand", op, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
